// File: rtl/lsu_mem_ctrl_if.sv
// Core/memory-side signal bundle for the load/store unit.
// slave is the unit's view; master is the view of whatever drives the core and memory sides.
interface lsu_mem_ctrl_if;
   // Core request side
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;

   // Core response side
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic        resp_err;

   // Data memory port
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
      output req_ready, stall, resp_valid, resp_rdata, resp_misalign, resp_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
      input  req_ready, stall, resp_valid, resp_rdata, resp_misalign, resp_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: width decode, lane steering, req/ack memory handshake with
// ack timeout, and sign/zero extension of load data.
module lsu_mem_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input logic                clk,
   input logic                rst,
   lsu_mem_ctrl_if.slave      bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [2:0]       ld_f3_q, ld_f3_d;
   logic [1:0]       ld_off_q, ld_off_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_misalign_q, resp_misalign_d;
   logic             resp_err_q, resp_err_d;
   logic [31:0]      resp_rdata_q, resp_rdata_d;

   logic             legal;
   logic             misalign;
   logic [3:0]       be_dec;
   logic [31:0]      wdata_dec;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      rd_ext;

   // Decode width/legality, byte enables and lane-replicated store data of the incoming request
   always_comb begin
      legal     = 1'b0;
      misalign  = 1'b0;
      be_dec    = 4'b0000;
      wdata_dec = 32'h0;
      unique case (bus.req_funct3)
         3'd0, 3'd4: begin
            legal  = (bus.req_funct3 == 3'd0) | ~bus.req_we;
            be_dec = 4'b0001 << bus.req_addr[1:0];
         end
         3'd1, 3'd5: begin
            legal    = (bus.req_funct3 == 3'd1) | ~bus.req_we;
            misalign = bus.req_addr[0];
            be_dec   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: begin
            legal    = 1'b1;
            misalign = (bus.req_addr[1:0] != 2'b00);
            be_dec   = 4'b1111;
         end
         default: legal = 1'b0;
      endcase
      if (bus.req_we) begin
         unique case (bus.req_funct3[1:0])
            2'd0:    wdata_dec = {4{bus.req_wdata[7:0]}};
            2'd1:    wdata_dec = {2{bus.req_wdata[15:0]}};
            default: wdata_dec = bus.req_wdata;
         endcase
      end
   end

   // Select the addressed lane of the returned word and extend it by the latched load type
   always_comb begin
      unique case (ld_off_q)
         2'd0:    rd_byte = bus.mem_rdata[7:0];
         2'd1:    rd_byte = bus.mem_rdata[15:8];
         2'd2:    rd_byte = bus.mem_rdata[23:16];
         default: rd_byte = bus.mem_rdata[31:24];
      endcase
      rd_half = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      unique case (ld_f3_q)
         3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
         3'd4:    rd_ext = {24'h0, rd_byte};
         3'd5:    rd_ext = {16'h0, rd_half};
         default: rd_ext = bus.mem_rdata;
      endcase
   end

   // Next-state logic for the IDLE -> REQ -> RESP access sequence
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      mem_req_d       = mem_req_q;
      mem_we_d        = mem_we_q;
      mem_addr_d      = mem_addr_q;
      mem_be_d        = mem_be_q;
      mem_wdata_d     = mem_wdata_q;
      ld_f3_d         = ld_f3_q;
      ld_off_d        = ld_off_q;
      resp_valid_d    = resp_valid_q;
      resp_misalign_d = resp_misalign_q;
      resp_err_d      = resp_err_q;
      resp_rdata_d    = resp_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (!legal || misalign) begin
                  // Faulting access never touches memory
                  state_d         = StResp;
                  resp_valid_d    = 1'b1;
                  resp_misalign_d = 1'b1;
                  resp_rdata_d    = 32'h0;
               end else begin
                  state_d     = StReq;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                  mem_be_d    = be_dec;
                  mem_wdata_d = wdata_dec;
                  ld_f3_d     = bus.req_funct3;
                  ld_off_d    = bus.req_addr[1:0];
               end
            end
         end
         StReq: begin
            // Ack wins over a timeout landing in the same cycle
            if (bus.mem_ack) begin
               state_d      = StResp;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = mem_we_q ? 32'h0 : rd_ext;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               state_d      = StResp;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d         = StIdle;
            resp_valid_d    = 1'b0;
            resp_misalign_d = 1'b0;
            resp_err_d      = 1'b0;
            resp_rdata_d    = 32'h0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset; reset abandons any in-flight access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= 32'h0;
         mem_be_q        <= 4'h0;
         mem_wdata_q     <= 32'h0;
         ld_f3_q         <= 3'd0;
         ld_off_q        <= 2'd0;
         resp_valid_q    <= 1'b0;
         resp_misalign_q <= 1'b0;
         resp_err_q      <= 1'b0;
         resp_rdata_q    <= 32'h0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         mem_req_q       <= mem_req_d;
         mem_we_q        <= mem_we_d;
         mem_addr_q      <= mem_addr_d;
         mem_be_q        <= mem_be_d;
         mem_wdata_q     <= mem_wdata_d;
         ld_f3_q         <= ld_f3_d;
         ld_off_q        <= ld_off_d;
         resp_valid_q    <= resp_valid_d;
         resp_misalign_q <= resp_misalign_d;
         resp_err_q      <= resp_err_d;
         resp_rdata_q    <= resp_rdata_d;
      end
   end

   assign bus.req_ready     = (state_q == StIdle);
   assign bus.stall         = bus.req_valid & ~resp_valid_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_rdata    = resp_rdata_q;
   assign bus.resp_misalign = resp_misalign_q;
   assign bus.resp_err      = resp_err_q;
   assign bus.mem_req       = mem_req_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_be        = mem_be_q;
   assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the core's ALU address and write-data outputs and the data memory port.
- Decodes RV32I load/store width from funct3 and generates word-aligned address, byte enables and lane-replicated store data.
- Runs a req/ack handshake with a variable-latency memory and sign/zero-extends load data.
- Stalls the core until the access completes, faults or times out.

Parameters:
- ACK_TIMEOUT, 16: cycles in REQ without mem_ack before the access is aborted with resp_err.
- CNT_W, 5: width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  core issues load/store this cycle
- req_ready  output  1  unit idle and able to accept; = (state==IDLE)
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I width/sign field
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data (rs2)
- stall  output  1  = req_valid & ~resp_valid; core holds PC and instruction
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_misalign  output  1  access was misaligned or had an illegal funct3; valid with resp_valid
- resp_err  output  1  memory ack timeout; valid with resp_valid
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  write strobe
- mem_addr  output  32  {req_addr[31:2],2'b00}
- mem_be  output  4  byte lane enables
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  read word, valid when mem_ack
- mem_ack  input  1  memory completes access this cycle

Behaviour:
- Reset values: state=IDLE; mem_req, mem_we, resp_valid, resp_misalign and resp_err are 0; mem_addr, mem_be, mem_wdata and resp_rdata are 0; counter is 0.
- Reset applies at any state. An in-flight access is abandoned, and mem_ack in the reset cycle is ignored.
- req_valid is ignored while rst is high.
- States: IDLE, REQ, RESP. All outputs except req_ready and stall are registered.
- IDLE, on req_valid:
  - Legal loads: funct3 = 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
  - Legal stores: funct3 = 0 sb, 1 sh, 2 sw.
  - Any other funct3 is illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned: go to RESP with resp_misalign=1. mem_req stays 0 and there is no memory side effect.
  - Otherwise: latch mem_addr, mem_be, mem_wdata, mem_we and the load type; set mem_req=1; clear the counter; go to REQ.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1]? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Loads drive the same byte enables.
- mem_wdata:
  - sb: {4{wdata[7:0]}}
  - sh: {2{wdata[15:0]}}
  - sw: wdata
  - Loads drive 0.
- REQ:
  - mem_req and all mem_* signals held stable.
  - On mem_ack: select the byte or halfword lane from mem_rdata by the latched addr[1:0], extend it (sign for lb/lh, zero for lbu/lhu, full word for lw), register the result into resp_rdata, drop mem_req, go to RESP.
  - Otherwise the counter increments. When counter == ACK_TIMEOUT-1 without ack: drop mem_req, set resp_err=1, resp_rdata=0, go to RESP.
  - mem_ack arriving in that same cycle takes priority over the timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_misalign, resp_err and resp_rdata clear on leaving RESP.
- Latency: acceptance in cycle 0 gives mem_req high from cycle 1. Zero-wait ack in cycle 1 gives resp_valid in cycle 2. Each wait cycle adds 1.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP; there is no acceptance in RESP.
- mem_ack outside REQ is ignored.

Test Plan:
- Zero-wait lw: addr=0x100, mem_rdata=0xDEADBEEF, ack in first REQ cycle -> mem_addr=0x100, mem_be=4'hF, resp_valid in cycle 2, resp_rdata=0xDEADBEEF, stall high in cycles 0-1.
- lb/lbu: addr=0x103, mem_rdata=0x80xxxxxx -> mem_be=4'b1000; lb returns 0xFFFFFF80, lbu returns 0x00000080. lh at addr=0x102 with rdata=0x8001xxxx returns 0xFFFF8001.
- sb/sh: req_wdata=0x12345678. sb at 0x201 -> mem_be=4'b0010, mem_wdata=0x78787878, mem_addr=0x200, mem_we=1. sh at 0x202 -> mem_be=4'b1100, mem_wdata=0x56785678.
- Misaligned and illegal: lw at 0x102 and load with funct3=3 -> mem_req never asserts, resp_valid one cycle after acceptance with resp_misalign=1, resp_rdata=0.
- Wait states and timeout: ack after 3 wait cycles -> mem_* signals stable throughout, resp_valid 3 cycles later. No ack with ACK_TIMEOUT=16 -> mem_req drops after 16 REQ cycles, resp_err=1, next request accepted normally.
- Reset mid-REQ: rst high for one cycle during REQ with mem_ack=1 -> next cycle all outputs at reset values, no resp_valid, req_ready=1.
